// File: rtl/bus_mux_reg.sv
// Registered bus-source multiplexer: priority select of DIN, G or the lowest-numbered
// general register, with select-conflict detection and sticky/saturating error tracking.
module bus_mux_reg #(
    parameter int WIDTH     = 9,
    parameter int NREGS     = 8,
    parameter bit HOLD_IDLE = 1'b1,
    parameter int ERR_W     = 8,
    localparam int SRC_W    = $clog2(NREGS + 2)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Bus_en,
    input  logic [NREGS-1:0]       R_out,
    input  logic                   G_out,
    input  logic                   DIN_out,
    input  logic [NREGS*WIDTH-1:0] R_data,
    input  logic [WIDTH-1:0]       G_data,
    input  logic [WIDTH-1:0]       DIN_data,
    input  logic                   Err_clr,
    output logic [WIDTH-1:0]       Bus,
    output logic                   Bus_valid,
    output logic [SRC_W-1:0]       Bus_src,
    output logic                   Sel_err,
    output logic                   Err_sticky,
    output logic [ERR_W-1:0]       Err_cnt
);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic             sel_err_q, sel_err_d;
    logic             sticky_q, sticky_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] win_data;
    logic [SRC_W-1:0] win_src;
    logic             sel_any;
    logic             conflict;
    logic             err_event;

    // Winner selection: DIN over G over the lowest set R_out bit.
    always_comb begin
        win_data = '0;
        win_src  = '0;
        if (DIN_out) begin
            win_data = DIN_data;
            win_src  = SRC_W'(NREGS + 1);
        end else if (G_out) begin
            win_data = G_data;
            win_src  = SRC_W'(NREGS);
        end else begin
            for (int i = NREGS - 1; i >= 0; i--) begin
                if (R_out[i]) begin
                    win_data = R_data[i*WIDTH +: WIDTH];
                    win_src  = SRC_W'(i);
                end
            end
        end
    end

    // More than one select: two of the single-bit sources, one of them plus any register,
    // or two register bits (clearing the lowest set bit leaves something behind).
    always_comb begin
        sel_any   = DIN_out | G_out | (|R_out);
        conflict  = (DIN_out & G_out) | ((DIN_out | G_out) & (|R_out))
                  | (|(R_out & (R_out - NREGS'(1))));
        err_event = Bus_en & conflict;
    end

    always_comb begin
        bus_d     = bus_q;
        valid_d   = valid_q;
        src_d     = src_q;
        sel_err_d = 1'b0;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;

        if (Bus_en) begin
            sel_err_d = conflict;
            if (sel_any) begin
                bus_d   = win_data;
                valid_d = 1'b1;
                src_d   = win_src;
            end else begin
                valid_d = 1'b0;
                if (!HOLD_IDLE) begin
                    bus_d = '0;
                end
            end
        end

        // A conflict sampled alongside a clear counts as the first event after the clear.
        if (Err_clr) begin
            sticky_d = err_event;
            cnt_d    = err_event ? ERR_W'(1) : '0;
        end else if (err_event) begin
            sticky_d = 1'b1;
            cnt_d    = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            bus_q     <= '0;
            valid_q   <= 1'b0;
            src_q     <= '0;
            sel_err_q <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            bus_q     <= bus_d;
            valid_q   <= valid_d;
            src_q     <= src_d;
            sel_err_q <= sel_err_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Bus        = bus_q;
    assign Bus_valid  = valid_q;
    assign Bus_src    = src_q;
    assign Sel_err    = sel_err_q;
    assign Err_sticky = sticky_q;
    assign Err_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Bench for bus_mux_reg: default build, a HOLD_IDLE=0 build and an ERR_W=2 build share
// the same stimulus and are compared against a per-build behavioural model.
module tb_bus_mux_reg;

    logic        Clock = 1'b0;
    logic        Reset, Bus_en, G_out, DIN_out, Err_clr;
    logic [7:0]  R_out;
    logic [71:0] R_data;
    logic [8:0]  G_data, DIN_data;

    logic [8:0] bus0, bus1, bus2;
    logic       vld0, vld1, vld2;
    logic [3:0] src0, src1, src2;
    logic       se0, se1, se2;
    logic       st0, st1, st2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    bus_mux_reg u_dflt (
        .Clock(Clock), .Reset(Reset), .Bus_en(Bus_en), .R_out(R_out), .G_out(G_out),
        .DIN_out(DIN_out), .R_data(R_data), .G_data(G_data), .DIN_data(DIN_data),
        .Err_clr(Err_clr), .Bus(bus0), .Bus_valid(vld0), .Bus_src(src0), .Sel_err(se0),
        .Err_sticky(st0), .Err_cnt(cnt0));

    bus_mux_reg #(.HOLD_IDLE(1'b0)) u_idle0 (
        .Clock(Clock), .Reset(Reset), .Bus_en(Bus_en), .R_out(R_out), .G_out(G_out),
        .DIN_out(DIN_out), .R_data(R_data), .G_data(G_data), .DIN_data(DIN_data),
        .Err_clr(Err_clr), .Bus(bus1), .Bus_valid(vld1), .Bus_src(src1), .Sel_err(se1),
        .Err_sticky(st1), .Err_cnt(cnt1));

    bus_mux_reg #(.ERR_W(2)) u_err2 (
        .Clock(Clock), .Reset(Reset), .Bus_en(Bus_en), .R_out(R_out), .G_out(G_out),
        .DIN_out(DIN_out), .R_data(R_data), .G_data(G_data), .DIN_data(DIN_data),
        .Err_clr(Err_clr), .Bus(bus2), .Bus_valid(vld2), .Bus_src(src2), .Sel_err(se2),
        .Err_sticky(st2), .Err_cnt(cnt2));

    // Behavioural model state, one slot per build.
    int m_bus[3], m_vld[3], m_src[3], m_se[3], m_st[3], m_cnt[3];
    int hold_p[3] = '{1, 0, 1};
    int cmax[3]   = '{255, 255, 3};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int n;
        int wd, ws;
        bit conf, ev;
        n    = $countones({DIN_out, G_out, R_out});
        conf = (n > 1);
        ev   = Bus_en && conf;
        wd = 0;
        ws = 0;
        if (DIN_out) begin
            wd = DIN_data; ws = 9;
        end else if (G_out) begin
            wd = G_data; ws = 8;
        end else begin
            for (int i = 7; i >= 0; i--)
                if (R_out[i]) begin wd = R_data[i*9 +: 9]; ws = i; end
        end
        for (int k = 0; k < 3; k++) begin
            if (Reset) begin
                m_bus[k] = 0; m_vld[k] = 0; m_src[k] = 0;
                m_se[k] = 0; m_st[k] = 0; m_cnt[k] = 0;
            end else begin
                m_se[k] = 0;
                if (Bus_en) begin
                    m_se[k] = conf;
                    if (n > 0) begin
                        m_bus[k] = wd; m_vld[k] = 1; m_src[k] = ws;
                    end else begin
                        m_vld[k] = 0;
                        if (hold_p[k] == 0) m_bus[k] = 0;
                    end
                end
                if (Err_clr) begin
                    m_st[k] = ev; m_cnt[k] = ev ? 1 : 0;
                end else if (ev) begin
                    m_st[k] = 1;
                    if (m_cnt[k] < cmax[k]) m_cnt[k]++;
                end
            end
        end
    endtask

    task automatic cmp_one(input int k, input logic [8:0] b, input logic v, input logic [3:0] s,
                           input logic e, input logic st, input logic [7:0] c);
        string p;
        p = $sformatf("dut%0d", k);
        chk({p, ".Bus"}, b, m_bus[k]);
        chk({p, ".Bus_valid"}, v, m_vld[k]);
        chk({p, ".Bus_src"}, s, m_src[k]);
        chk({p, ".Sel_err"}, e, m_se[k]);
        chk({p, ".Err_sticky"}, st, m_st[k]);
        chk({p, ".Err_cnt"}, c, m_cnt[k]);
    endtask

    // Clock one edge, advance the model, then compare all builds just after the edge.
    task automatic tick();
        @(posedge Clock);
        model_step();
        #1;
        cmp_one(0, bus0, vld0, src0, se0, st0, cnt0);
        cmp_one(1, bus1, vld1, src1, se1, st1, cnt1);
        cmp_one(2, bus2, vld2, src2, se2, st2, {6'd0, cnt2});
    endtask

    task automatic drive(input bit rst, input bit en, input logic [7:0] r, input bit g,
                         input bit d, input bit clr);
        Reset = rst; Bus_en = en; R_out = r; G_out = g; DIN_out = d; Err_clr = clr;
    endtask

    typedef struct {
        bit         rst, en, clr, g, din;
        logic [7:0] r;
        logic [8:0] e_bus;
        bit         e_vld;
        logic [3:0] e_src;
        bit         e_se, e_st;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vt[14];

    initial begin
        // Fixed register file: R0..R7
        R_data   = {9'h0F7, 9'h166, 9'h0B5, 9'h1C4, 9'h055, 9'h0A5, 9'h122, 9'h011};
        G_data   = 9'h033;
        DIN_data = 9'h1FF;

        //         rst en clr g din  r_out     bus    vld src se st cnt
        vt[0]  = '{1, 1, 0, 1, 1, 8'hFF, 9'h000, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 1, 1, 0, 1, 8'h5A, 9'h000, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 0, 0, 0, 8'h04, 9'h0A5, 1, 2, 0, 0, 0};
        vt[3]  = '{0, 1, 0, 1, 1, 8'h80, 9'h1FF, 1, 9, 1, 1, 1};
        vt[4]  = '{0, 1, 0, 0, 0, 8'h03, 9'h011, 1, 0, 1, 1, 2};
        vt[5]  = '{0, 1, 0, 0, 0, 8'h08, 9'h055, 1, 3, 0, 1, 2};
        vt[6]  = '{0, 1, 0, 0, 0, 8'h00, 9'h055, 0, 3, 0, 1, 2};
        vt[7]  = '{0, 0, 0, 1, 1, 8'hFF, 9'h055, 0, 3, 0, 1, 2};
        vt[8]  = '{0, 0, 0, 1, 0, 8'h81, 9'h055, 0, 3, 0, 1, 2};
        vt[9]  = '{0, 0, 0, 1, 1, 8'h30, 9'h055, 0, 3, 0, 1, 2};
        vt[10] = '{0, 1, 0, 1, 0, 8'h00, 9'h033, 1, 8, 0, 1, 2};
        vt[11] = '{0, 1, 1, 0, 0, 8'h00, 9'h033, 0, 8, 0, 0, 0};
        vt[12] = '{1, 1, 1, 1, 1, 8'hFF, 9'h000, 0, 0, 0, 0, 0};
        vt[13] = '{0, 1, 0, 0, 0, 8'h01, 9'h011, 1, 0, 0, 0, 0};

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].rst, vt[i].en, vt[i].r, vt[i].g, vt[i].din, vt[i].clr);
            tick();
            chk($sformatf("vec%0d.Bus", i), bus0, vt[i].e_bus);
            chk($sformatf("vec%0d.Bus_valid", i), vld0, vt[i].e_vld);
            chk($sformatf("vec%0d.Bus_src", i), src0, vt[i].e_src);
            chk($sformatf("vec%0d.Sel_err", i), se0, vt[i].e_se);
            chk($sformatf("vec%0d.Err_sticky", i), st0, vt[i].e_st);
            chk($sformatf("vec%0d.Err_cnt", i), cnt0, vt[i].e_cnt);
            if (i == 6) begin
                chk("idle0.Bus_zeroed", bus1, 9'h000);
                chk("idle0.Bus_src_held", src1, 4'd3);
                chk("idle0.Bus_valid", vld1, 1'b0);
            end
        end

        // Saturation of the 2-bit counter, then clear alone, then clear with a conflict.
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, 8'h00, 1, 1, 0);
            tick();
            chk($sformatf("sat%0d.Err_cnt", i), {6'd0, cnt2}, (i > 3) ? 3 : i);
            chk($sformatf("sat%0d.Err_sticky", i), st2, 1'b1);
        end
        chk("nosat.Err_cnt", cnt0, 8'd5);
        drive(0, 1, 8'h00, 0, 0, 1);
        tick();
        chk("clr.Err_cnt", {6'd0, cnt2}, 0);
        chk("clr.Err_sticky", st2, 1'b0);
        drive(0, 1, 8'h11, 0, 0, 1);
        tick();
        chk("clr_conf.Err_cnt", {6'd0, cnt2}, 1);
        chk("clr_conf.Err_sticky", st2, 1'b1);
        chk("clr_conf.Bus_src", src2, 4'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            Reset   = ($urandom_range(0, 39) == 0);
            Bus_en  = ($urandom_range(0, 4) != 0);
            Err_clr = ($urandom_range(0, 9) == 0);
            G_out   = ($urandom_range(0, 3) == 0);
            DIN_out = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0: R_out = 8'h00;
                1: R_out = 8'h01 << $urandom_range(0, 7);
                default: R_out = 8'($urandom());
            endcase
            R_data   = {$urandom(), $urandom(), $urandom()};
            G_data   = 9'($urandom());
            DIN_data = 9'($urandom());
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised, registered successor to the processor's combinational bus-source multiplexer.
- Selects one of NREGS general registers, the ALU result register G, or the external DIN onto the shared processor bus. Output is registered, giving 1-cycle latency.
- Adds conflict detection for multiple-select, configurable idle behaviour (hold or zero), and a source tag.
- Adds sticky and saturating error counters, readable by the control FSM or debug logic.

Parameters:
- WIDTH, 9, data width of every source and of Bus.
- NREGS, 8, number of general registers (≥2). R_out is one-hot over these.
- HOLD_IDLE, 1: with no source selected, 1 = Bus keeps its last value; 0 = Bus loads all-zeros.
- ERR_W, 8, width of the saturating conflict counter.
- Local SRC_W = clog2(NREGS+2). Source IDs: 0..NREGS-1 = R0..R(NREGS-1), NREGS = G, NREGS+1 = DIN.

Ports:
- Clock, input, 1: single clock; all state updates on rising edge.
- Reset, input, 1: synchronous, active-high.
- Bus_en, input, 1: 1 = sample selects this cycle; 0 = all state holds.
- R_out, input, NREGS: one-hot register-drive select.
- G_out, input, 1: drive G onto bus.
- DIN_out, input, 1: drive DIN onto bus.
- R_data, input, NREGS*WIDTH: register contents, Ri at bits [i*WIDTH +: WIDTH].
- G_data, input, WIDTH: G register contents.
- DIN_data, input, WIDTH: external data in.
- Err_clr, input, 1: clears Err_sticky and Err_cnt.
- Bus, output, WIDTH: registered bus value.
- Bus_valid, output, 1: 1 = Bus was loaded from a source in the last enabled cycle.
- Bus_src, output, SRC_W: source ID of the last valid drive.
- Sel_err, output, 1: 1-cycle pulse; the last enabled cycle had a select conflict.
- Err_sticky, output, 1: set on any conflict until cleared.
- Err_cnt, output, ERR_W: conflict count, saturating at 2^ERR_W-1.

Behaviour:
- Reset (synchronous, wins over everything): Bus=0, Bus_valid=0, Bus_src=0, Sel_err=0, Err_sticky=0, Err_cnt=0. Reset asserted mid-stream discards the in-flight selection.
- Priority when Bus_en=1:
  - DIN_out=1: source = DIN.
  - Else G_out=1: source = G.
  - Else lowest set bit i of R_out: source = Ri.
  - Winner data appears on Bus in the next cycle (latency 1). Bus_valid=1, Bus_src=winner ID.
- Conflict: total count of asserted bits among {DIN_out, G_out, R_out[*]} > 1.
  - Winner is still driven per the priority rule.
  - Sel_err=1 the next cycle, else 0.
  - Err_sticky set.
  - Err_cnt increments; holds at max with no wrap.
- Idle (Bus_en=1, no select asserted):
  - Bus_valid=0. Bus_src holds.
  - HOLD_IDLE=1: Bus holds. HOLD_IDLE=0: Bus=0.
  - Sel_err=0.
- Bus_en=0:
  - Bus, Bus_valid, Bus_src, Err_sticky, Err_cnt hold.
  - Sel_err forced 0.
  - Selects are ignored, so no conflict is counted.
- Err_clr=1 (no Reset):
  - Err_sticky=0, Err_cnt=0, unless a conflict is sampled the same cycle. In that case the new event wins: Err_sticky=1, Err_cnt=1.
  - Err_clr does not affect Bus, Bus_valid, Bus_src or Sel_err.
- Behaviour is purely positional and must not depend on source data values. Outputs come only from registers, with no combinational input-to-output path.

Test Plan:
- Reset=1 for 2 cycles with random inputs -> all outputs 0. Release, Bus_en=1, R_out=8'b00000100, R2=9'h0A5 -> next cycle Bus=9'h0A5, Bus_valid=1, Bus_src=2, Sel_err=0.
- DIN_out=1, G_out=1, R_out=8'b10000000, DIN=9'h1FF, G=9'h033 -> Bus=9'h1FF, Bus_src=9, Sel_err pulses 1 cycle, Err_sticky=1, Err_cnt=1. Then R_out=8'b00000011 -> Bus=R0, Bus_src=0, Err_cnt=2.
- Idle: load 9'h055, then all selects 0 -> HOLD_IDLE=1: Bus stays 9'h055, Bus_valid=0. HOLD_IDLE=0 build: Bus=0, Bus_valid=0, Bus_src still the previous ID.
- ERR_W=2: 5 consecutive conflict cycles -> Err_cnt=3 (saturated). Err_clr alone -> 0, Err_sticky=0. Err_clr plus conflict in the same cycle -> Err_cnt=1, Err_sticky=1.
- Bus_en=0 with conflicting selects and G_out=1 for 3 cycles -> all outputs unchanged, Sel_err=0, Err_cnt unchanged. Then Bus_en=1, G_out=1 -> Bus=G, Bus_src=8.
- Reset asserted in the same cycle as a conflict and Err_clr -> next cycle everything 0, no error recorded.
